pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the MIPS monocycle core, replacing the plain PC register. It holds the fetch address, selects the next PC (sequential, branch, jump, return, exception, exception-return), and supports stall. It also keeps an exception PC (EPC) and a small return-address stack (RAS) for `jal`/`jr $ra`. It sits between the control unit / branch comparator and the instruction memory address port.

## Interface
- `WIDTH`, 32, address width in bits (≥ 8)
- `RESET_VECTOR`, 32'h0000_0000, PC value after reset
- `EXC_VECTOR`, 32'h0000_0080, PC loaded on exception
- `RAS_DEPTH`, 4, return-stack entries (power of 2, ≥ 2)

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `Reset`  in  1  synchronous, active-high reset
- `Stall`  in  1  hold PC, RAS and EPC
- `BranchTaken`  in  1  redirect to `BranchTarget`
- `BranchTarget`  in  WIDTH  branch target address
- `Jump`  in  1  redirect to `JumpTarget`
- `JumpLink`  in  1  with `Jump`: push `PCPlus4` onto RAS
- `Return`  in  1  pop RAS, redirect to popped address
- `JumpTarget`  in  WIDTH  jump target; fallback for `Return` when RAS is empty
- `Exception`  in  1  trap request from the current instruction
- `Eret`  in  1  return from exception
- `PC`  out  WIDTH  current fetch address (registered)
- `PCPlus4`  out  WIDTH  `PC + 4`, combinational, wraps modulo 2^WIDTH
- `EPC`  out  WIDTH  saved exception PC (registered)
- `AlignErr`  out  1  registered, high one cycle after a misaligned redirect was trapped
- `RasUnderflow`  out  1  registered, high one cycle after a `Return` on an empty RAS
- `RasEmpty`, `RasFull`  out  1  combinational from the RAS count

## Operation
The next PC is chosen by strict priority:
1. `Reset`: PC=RESET_VECTOR; EPC=0; RAS count=0, pointer=0; all flags 0.
2. `Exception`: EPC←PC; PC←EXC_VECTOR. Overrides `Stall`.
3. `Eret`: PC←EPC. Ignored when `Stall` is high.
4. `Stall`: nothing changes and no flags are set.
5. `Return`: PC←RAS top and pop. If the RAS is empty: PC←`JumpTarget` and `RasUnderflow`←1.
6. `Jump`: PC←`JumpTarget`. If `JumpLink` is high, push `PCPlus4`.
7. `BranchTaken`: PC←`BranchTarget`.
8. Otherwise: PC←`PCPlus4`.

Alignment:
- If the selected redirect target (priorities 5–7) has bits[1:0] ≠ 0, it is treated as an exception.
- EPC←PC, PC←EXC_VECTOR, `AlignErr`←1.
- No RAS push or pop happens on that cycle.

RAS behaviour:
- Circular buffer with a write pointer and a saturating count (0..RAS_DEPTH).
- Push when full overwrites the oldest entry; the count stays RAS_DEPTH.
- `JumpLink` without `Jump` is ignored.
- `Return` together with `Jump` means `Return` wins and no push occurs.

Flags:
- `AlignErr` and `RasUnderflow` clear on the next unstalled cycle.
- While `Stall` is high they hold their value.

## Timing
- Every update takes effect at the posedge after its request. Redirect latency is 1 cycle, and the new PC is visible right after the edge.
- `PCPlus4`, `RasEmpty` and `RasFull` follow the registers combinationally, with zero latency.
- `Reset` asserted mid-operation wins on that edge regardless of the other inputs. PC reads RESET_VECTOR on the following cycle.
- An `Exception` during `Stall` still captures EPC=PC (the stalled PC).

## Structure
- Package `pc_pkg` holds:
  - enum `npc_sel_t` {NPC_RESET, NPC_EXC, NPC_ERET, NPC_HOLD, NPC_RET, NPC_JUMP, NPC_BRANCH, NPC_SEQ}
  - constant `INSTR_BYTES` = 4
- Sub-module `pc_ras` holds the return stack: WIDTH, DEPTH; ports push, pop, din, dout, empty, full. The pointer wraps modulo DEPTH.
- `pc_unit` contains the priority select, the alignment check, and the PC, EPC and flag registers.

## Test plan
- **Reset and sequential fetch:** `Reset`=1 for 2 cycles, then 3 idle cycles → PC = 0x0, 0x4, 0x8, 0xC. `PCPlus4` always equals PC+4.
- **Redirects and stall:** at PC=0x10, `BranchTaken` with target 0x40 → PC=0x40. `Jump` to 0x100 → PC=0x100. Then `Stall` for 2 cycles → PC stays 0x100.
- **RAS round trip:** `Jump`+`JumpLink` at PC=0x20 to 0x200 pushes 0x24. At 0x204, `Return` → PC=0x24 and `RasEmpty`=1.
- **RAS overflow and underflow:** 5 linked jumps with RAS_DEPTH=4 → `RasFull`=1. Then 4 `Return`s yield the last 4 links in LIFO order. A 5th `Return` with `JumpTarget`=0x300 → PC=0x300 and `RasUnderflow`=1 for one cycle.
- **Exception and Eret:** at PC=0x50, `Exception` with `Stall`=1 → PC=0x80, EPC=0x50. `Eret` → PC=0x50.
- **Misaligned target:** `Jump` to 0x102 at PC=0x60 → PC=0x80, EPC=0x60, `AlignErr`=1 for one cycle, RAS unchanged.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

    // Next-PC source, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        NPC_RESET,
        NPC_EXC,
        NPC_ERET,
        NPC_HOLD,
        NPC_RET,
        NPC_JUMP,
        NPC_BRANCH,
        NPC_SEQ
    } npc_sel_t;

    // Size of one instruction in bytes; the sequential PC step.
    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the core control path and the PC unit.
interface pc_unit_if #(
    parameter int WIDTH = 32
) ();

    logic             Stall;
    logic             BranchTaken;
    logic [WIDTH-1:0] BranchTarget;
    logic             Jump;
    logic             JumpLink;
    logic             Return;
    logic [WIDTH-1:0] JumpTarget;
    logic             Exception;
    logic             Eret;

    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] PCPlus4;
    logic [WIDTH-1:0] EPC;
    logic             AlignErr;
    logic             RasUnderflow;
    logic             RasEmpty;
    logic             RasFull;

    // Control unit side: drives redirect requests, observes the PC state.
    modport master (
        output Stall, BranchTaken, BranchTarget, Jump, JumpLink, Return,
               JumpTarget, Exception, Eret,
        input  PC, PCPlus4, EPC, AlignErr, RasUnderflow, RasEmpty, RasFull
    );

    // PC unit side.
    modport slave (
        input  Stall, BranchTaken, BranchTarget, Jump, JumpLink, Return,
               JumpTarget, Exception, Eret,
        output PC, PCPlus4, EPC, AlignErr, RasUnderflow, RasEmpty, RasFull
    );

endinterface

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a saturating entry count.
// A push when full silently overwrites the oldest entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    count;

    assign dout  = mem[ptr - PW'(1)];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Pointer and count bookkeeping; push and pop are never requested together.
    always_ff @(posedge clk) begin
        if (Reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

    // Entry storage is written at the slot the pointer names.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC priority select, alignment trap,
// exception PC and return-address stack for the monocycle core.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 'h80,
    parameter int               RAS_DEPTH    = 4
) (
    input logic        clk,
    input logic        Reset,
    pc_unit_if.slave   bus
);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] epc;
    logic             align_err;
    logic             ras_underflow;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             ras_full;
    npc_sel_t         sel;
    logic [WIDTH-1:0] target;
    logic             misaligned;
    logic             ras_push;
    logic             ras_pop;

    assign pc_plus4 = pc + WIDTH'(INSTR_BYTES);

    // Pick the next-PC source by strict priority; Eret yields to Stall.
    always_comb begin
        sel = NPC_SEQ;
        if (Reset)                sel = NPC_RESET;
        else if (bus.Exception)   sel = NPC_EXC;
        else if (bus.Stall)       sel = NPC_HOLD;
        else if (bus.Eret)        sel = NPC_ERET;
        else if (bus.Return)      sel = NPC_RET;
        else if (bus.Jump)        sel = NPC_JUMP;
        else if (bus.BranchTaken) sel = NPC_BRANCH;
    end

    // Resolve the redirect target and trap it if it is not word aligned.
    always_comb begin
        target     = pc_plus4;
        misaligned = 1'b0;
        case (sel)
            NPC_RET:    target = ras_empty ? bus.JumpTarget : ras_top;
            NPC_JUMP:   target = bus.JumpTarget;
            NPC_BRANCH: target = bus.BranchTarget;
            default:    target = pc_plus4;
        endcase
        if ((sel == NPC_RET) || (sel == NPC_JUMP) || (sel == NPC_BRANCH)) begin
            misaligned = (target[1:0] != 2'b00);
        end
    end

    // A trapped redirect must leave the stack untouched.
    assign ras_push = (sel == NPC_JUMP) && bus.JumpLink && !misaligned;
    assign ras_pop  = (sel == NPC_RET) && !misaligned;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .Reset (Reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_plus4),
        .dout  (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    // PC, EPC and sticky-for-one-cycle flags; flags freeze while stalled.
    always_ff @(posedge clk) begin
        if (Reset) begin
            pc            <= RESET_VECTOR;
            epc           <= '0;
            align_err     <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            if (!bus.Stall) begin
                align_err     <= 1'b0;
                ras_underflow <= 1'b0;
            end
            if (misaligned) begin
                epc       <= pc;
                pc        <= EXC_VECTOR;
                align_err <= 1'b1;
            end else begin
                case (sel)
                    NPC_EXC: begin
                        epc <= pc;
                        pc  <= EXC_VECTOR;
                    end
                    NPC_ERET: pc <= epc;
                    NPC_HOLD: pc <= pc;
                    NPC_RET: begin
                        pc <= target;
                        if (ras_empty) begin
                            ras_underflow <= 1'b1;
                        end
                    end
                    default: pc <= target;
                endcase
            end
        end
    end

    assign bus.PC           = pc;
    assign bus.PCPlus4      = pc_plus4;
    assign bus.EPC          = epc;
    assign bus.AlignErr     = align_err;
    assign bus.RasUnderflow = ras_underflow;
    assign bus.RasEmpty     = ras_empty;
    assign bus.RasFull      = ras_full;

endmodule
